// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX decode/issue slice.
// Contents: ALU op code enum, RV32I opcode and funct3/funct7 constants,
// and the id_ex_t bundle that is carried in the ID/EX pipeline register.
package riscv_pkg;

  localparam int PKG_XLEN   = 32;
  localparam int PKG_REG_AW = 5;

  // The execute stage expects exactly these 4-bit codes.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_SLLI = 4'b1010,
    ALU_SRLI = 4'b1011,
    ALU_SRAI = 4'b1100,
    ALU_LUI  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 values for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 values for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 values for LOAD / STORE / JALR
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Everything the execute stage needs from one decoded instruction.
  typedef struct packed {
    logic [PKG_XLEN-1:0]   r1;
    logic [PKG_XLEN-1:0]   r2;
    alu_op_e               aluControl;
    logic [PKG_REG_AW-1:0] rd;
    logic                  rdWe;
    logic                  memRe;
    logic                  memWe;
    logic                  branch;
    logic [2:0]            funct3;
    logic                  illegal;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_decode.sv
// Purely combinational RV32I decoder for the ID/EX stage.
// Ports:
//   instr_i     instruction word
//   pc_i        instruction PC (used by AUIPC / JAL / JALR operands)
//   rs1_data_i  register-file read data for rs1
//   rs2_data_i  register-file read data for rs2
//   decoded_o   id_ex_t bundle ready to be registered
module id_decode
  import riscv_pkg::*;
(
  input  logic [31:0]         instr_i,
  input  logic [PKG_XLEN-1:0] pc_i,
  input  logic [PKG_XLEN-1:0] rs1_data_i,
  input  logic [PKG_XLEN-1:0] rs2_data_i,
  output id_ex_t              decoded_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rdField;
  logic [31:0] immI;
  logic [31:0] immS;
  logic [31:0] immU;
  logic [31:0] shamtImm;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign rdField  = instr_i[11:7];
  assign immI     = {{20{instr_i[31]}}, instr_i[31:20]};
  assign immS     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign immU     = {instr_i[31:12], 12'b0};
  assign shamtImm = {27'b0, instr_i[24:20]};

  // Opcode-driven decode. Each legal case fills in operands, op code and
  // side-band; anything unrecognised sets isIllegal, and the final block
  // then replaces the whole bundle with a harmless ADD of zeros so an
  // illegal slot can travel down the pipe without side effects.
  logic   isIllegal;
  logic   writesRd;
  id_ex_t dec;

  always_comb begin
    dec            = '0;
    dec.aluControl = ALU_ADD;
    isIllegal      = 1'b0;
    writesRd       = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        dec.r1   = rs1_data_i;
        dec.r2   = rs2_data_i;
        writesRd = 1'b1;
        if (funct7 == F7_ZERO) begin
          unique case (funct3)
            F3_ADD:  dec.aluControl = ALU_ADD;
            F3_SLL:  dec.aluControl = ALU_SLL;
            F3_SLT:  dec.aluControl = ALU_SLT;
            F3_SLTU: dec.aluControl = ALU_SLTU;
            F3_XOR:  dec.aluControl = ALU_XOR;
            F3_SR:   dec.aluControl = ALU_SRL;
            F3_OR:   dec.aluControl = ALU_OR;
            default: dec.aluControl = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec.aluControl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          dec.aluControl = ALU_SRA;
        end else begin
          isIllegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        dec.r1   = rs1_data_i;
        dec.r2   = immI;
        writesRd = 1'b1;
        unique case (funct3)
          F3_ADD:  dec.aluControl = ALU_ADD;
          F3_SLT:  dec.aluControl = ALU_SLT;
          F3_SLTU: dec.aluControl = ALU_SLTU;
          F3_XOR:  dec.aluControl = ALU_XOR;
          F3_OR:   dec.aluControl = ALU_OR;
          F3_AND:  dec.aluControl = ALU_AND;
          F3_SLL: begin
            dec.r2         = shamtImm;
            dec.aluControl = ALU_SLLI;
            isIllegal      = (funct7 != F7_ZERO);
          end
          default: begin
            dec.r2 = shamtImm;
            if (funct7 == F7_ZERO)     dec.aluControl = ALU_SRLI;
            else if (funct7 == F7_ALT) dec.aluControl = ALU_SRAI;
            else                       isIllegal      = 1'b1;
          end
        endcase
      end

      OPC_LUI: begin
        dec.aluControl = ALU_LUI;
        dec.r1         = {12'b0, instr_i[31:12]};
        writesRd       = 1'b1;
      end

      OPC_AUIPC: begin
        dec.r1   = pc_i;
        dec.r2   = immU;
        writesRd = 1'b1;
      end

      OPC_LOAD: begin
        dec.r1    = rs1_data_i;
        dec.r2    = immI;
        dec.memRe = 1'b1;
        writesRd  = 1'b1;
        isIllegal = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                      funct3 == F3_LBU || funct3 == F3_LHU);
      end

      OPC_STORE: begin
        dec.r1    = rs1_data_i;
        dec.r2    = immS;
        dec.memWe = 1'b1;
        isIllegal = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW);
      end

      OPC_BRANCH: begin
        dec.r1     = rs1_data_i;
        dec.r2     = rs2_data_i;
        dec.branch = 1'b1;
        unique case (funct3)
          F3_BEQ, F3_BNE:   dec.aluControl = ALU_SUB;
          F3_BLT, F3_BGE:   dec.aluControl = ALU_SLT;
          F3_BLTU, F3_BGEU: dec.aluControl = ALU_SLTU;
          default:          isIllegal      = 1'b1;
        endcase
      end

      // Link value pc+4 is computed by the ALU; the target is handled elsewhere.
      OPC_JAL, OPC_JALR: begin
        dec.r1    = pc_i;
        dec.r2    = 32'd4;
        writesRd  = 1'b1;
        isIllegal = (opcode == OPC_JALR) && (funct3 != F3_JALR);
      end

      default: isIllegal = 1'b1;
    endcase
  end

  // Final assembly: x0 never gets a writeback, and an illegal encoding
  // collapses to a side-effect-free bundle flagged as illegal.
  always_comb begin
    decoded_o = dec;
    decoded_o.funct3 = funct3;
    decoded_o.rd     = writesRd ? rdField : '0;
    decoded_o.rdWe   = writesRd && (rdField != 5'd0);
    if (isIllegal) begin
      decoded_o            = '0;
      decoded_o.aluControl = ALU_ADD;
      decoded_o.funct3     = funct3;
      decoded_o.illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes an RV32I instruction and holds the result in the
// ID/EX pipeline register behind a valid/ready handshake on both sides.
// Ports:
//   clk_i, rst_ni                   clock and asynchronous active-low reset
//   flush_i                         kill the registered slot, drop input
//   in_valid_i / in_ready_o         upstream handshake
//   instr_i, pc_i, rs1/rs2_data_i   instruction bundle
//   out_valid_o / out_ready_i       downstream handshake
//   r1_o, r2_o, alu_control_o       ALU operand bundle
//   rd_o, rd_we_o, mem_re_o, mem_we_o, branch_o, funct3_o, illegal_o  side-band
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   r1_o,
  output logic [XLEN-1:0]   r2_o,
  output logic [3:0]        alu_control_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              rd_we_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic              branch_o,
  output logic [2:0]        funct3_o,
  output logic              illegal_o
);

  id_ex_t decoded;
  id_ex_t bundle_q, bundle_d;
  logic   slotValid_q, slotValid_d;
  logic   accept;

  id_decode u_decode (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .decoded_o  (decoded)
  );

  // Ready while the slot is empty or draining; during a flush the input is
  // swallowed (ready, but not accepted) so upstream does not stall on it.
  assign in_ready_o = !slotValid_q || out_ready_i || flush_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  // Next-state: flush wins, then a new accept, then a plain drain. The
  // payload only moves on accept, so a stalled slot holds every output.
  always_comb begin
    slotValid_d = slotValid_q;
    bundle_d    = bundle_q;
    if (flush_i) begin
      slotValid_d = 1'b0;
    end else if (accept) begin
      slotValid_d = 1'b1;
      bundle_d    = decoded;
    end else if (out_ready_i) begin
      slotValid_d = 1'b0;
    end
  end

  // The pipeline register itself; reset clears the whole slot at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slotValid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      slotValid_q <= slotValid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid_o   = slotValid_q;
  assign r1_o          = bundle_q.r1;
  assign r2_o          = bundle_q.r2;
  assign alu_control_o = bundle_q.aluControl;
  assign rd_o          = bundle_q.rd;
  assign rd_we_o       = bundle_q.rdWe;
  assign mem_re_o      = bundle_q.memRe;
  assign mem_we_o      = bundle_q.memWe;
  assign branch_o      = bundle_q.branch;
  assign funct3_o      = bundle_q.funct3;
  assign illegal_o     = bundle_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, decode of several encodings,
// backpressure, flush, illegal encodings and asynchronous reset mid-stall.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        outValid;
  logic        outReady;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [3:0]  aluControl;
  logic [4:0]  rd;
  logic        rdWe;
  logic        memRe;
  logic        memWe;
  logic        branch;
  logic [2:0]  funct3;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .in_valid_i    (inValid),
    .in_ready_o    (inReady),
    .instr_i       (instr),
    .pc_i          (pc),
    .rs1_data_i    (rs1Data),
    .rs2_data_i    (rs2Data),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .r1_o          (r1),
    .r2_o          (r2),
    .alu_control_o (aluControl),
    .rd_o          (rd),
    .rd_we_o       (rdWe),
    .mem_re_o      (memRe),
    .mem_we_o      (memWe),
    .branch_o      (branch),
    .funct3_o      (funct3),
    .illegal_o     (illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction bundle onto the upstream interface.
  task automatic applyStimulus(input logic valid, input logic [31:0] ins,
                               input logic [31:0] pcVal, input logic [31:0] a,
                               input logic [31:0] b);
    inValid = valid;
    instr   = ins;
    pc      = pcVal;
    rs1Data = a;
    rs2Data = b;
  endtask

  // One comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"},   32'(outValid),   32'h0);
    checkOutput({tag, ".r1"},      r1,              32'h0);
    checkOutput({tag, ".r2"},      r2,              32'h0);
    checkOutput({tag, ".alu"},     32'(aluControl), 32'h0);
    checkOutput({tag, ".rd"},      32'(rd),         32'h0);
    checkOutput({tag, ".rdWe"},    32'(rdWe),       32'h0);
    checkOutput({tag, ".memRe"},   32'(memRe),      32'h0);
    checkOutput({tag, ".memWe"},   32'(memWe),      32'h0);
    checkOutput({tag, ".branch"},  32'(branch),     32'h0);
    checkOutput({tag, ".funct3"},  32'(funct3),     32'h0);
    checkOutput({tag, ".illegal"}, 32'(illegal),    32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    outReady = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    tick();
    tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("reset.inReady", 32'(inReady), 32'h1);

    // ADDI x5, x1, -3
    outReady = 1'b1;
    applyStimulus(1'b1, 32'hFFD08293, 32'h100, 32'd10, 32'h0);
    tick();
    checkOutput("addi.valid", 32'(outValid),   32'h1);
    checkOutput("addi.alu",   32'(aluControl), 32'h0);
    checkOutput("addi.r1",    r1,              32'd10);
    checkOutput("addi.r2",    r2,              32'hFFFFFFFD);
    checkOutput("addi.rd",    32'(rd),         32'd5);
    checkOutput("addi.rdWe",  32'(rdWe),       32'h1);

    // SRAI x3, x2, 4 (back-to-back)
    applyStimulus(1'b1, 32'h40415193, 32'h104, 32'h80000000, 32'h0);
    tick();
    checkOutput("srai.valid", 32'(outValid),   32'h1);
    checkOutput("srai.alu",   32'(aluControl), 32'hC);
    checkOutput("srai.r1",    r1,              32'h80000000);
    checkOutput("srai.r2",    r2,              32'h4);
    checkOutput("srai.rd",    32'(rd),         32'd3);

    // LUI x7, 0x12345
    applyStimulus(1'b1, 32'h123453B7, 32'h108, 32'hDEADBEEF, 32'hCAFEF00D);
    tick();
    checkOutput("lui.alu",  32'(aluControl), 32'hD);
    checkOutput("lui.r1",   r1,              32'h00012345);
    checkOutput("lui.r2",   r2,              32'h0);
    checkOutput("lui.rd",   32'(rd),         32'd7);
    checkOutput("lui.rdWe", 32'(rdWe),       32'h1);

    // Backpressure: SUB x6, x1, x2 waits while LUI is held
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h40208333, 32'h10C, 32'd7, 32'd8);
    #1;
    checkOutput("stall.inReady", 32'(inReady), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall.valid",   32'(outValid),   32'h1);
      checkOutput("stall.alu",     32'(aluControl), 32'hD);
      checkOutput("stall.r1",      r1,              32'h00012345);
      checkOutput("stall.rd",      32'(rd),         32'd7);
      checkOutput("stall.inReady", 32'(inReady),    32'h0);
    end
    outReady = 1'b1;
    #1;
    checkOutput("release.inReady", 32'(inReady), 32'h1);
    tick();
    checkOutput("sub.valid", 32'(outValid),   32'h1);
    checkOutput("sub.alu",   32'(aluControl), 32'h8);
    checkOutput("sub.r1",    r1,              32'd7);
    checkOutput("sub.r2",    r2,              32'd8);
    checkOutput("sub.rd",    32'(rd),         32'd6);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("drain.valid", 32'(outValid), 32'h0);

    // Flush with a valid slot and a concurrent input
    applyStimulus(1'b1, 32'hFFD08293, 32'h200, 32'd1, 32'h0);
    tick();
    checkOutput("preflush.valid", 32'(outValid), 32'h1);
    outReady = 1'b0;
    flush    = 1'b1;
    applyStimulus(1'b1, 32'h123453B7, 32'h204, 32'h0, 32'h0);
    #1;
    checkOutput("flush.inReady", 32'(inReady), 32'h1);
    tick();
    flush    = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("flush.valid", 32'(outValid), 32'h0);
    tick();
    checkOutput("flush.dropped", 32'(outValid), 32'h0);

    // BEQ x1, x2 after the flush
    applyStimulus(1'b1, 32'h00208463, 32'h208, 32'd3, 32'd4);
    tick();
    checkOutput("beq.valid",  32'(outValid),   32'h1);
    checkOutput("beq.alu",    32'(aluControl), 32'h8);
    checkOutput("beq.branch", 32'(branch),     32'h1);
    checkOutput("beq.funct3", 32'(funct3),     32'h0);
    checkOutput("beq.rdWe",   32'(rdWe),       32'h0);
    checkOutput("beq.r1",     r1,              32'd3);
    checkOutput("beq.r2",     r2,              32'd4);

    // LW x9, 8(x1)
    applyStimulus(1'b1, 32'h0080A483, 32'h20C, 32'h1000, 32'h0);
    tick();
    checkOutput("lw.memRe",  32'(memRe),      32'h1);
    checkOutput("lw.memWe",  32'(memWe),      32'h0);
    checkOutput("lw.alu",    32'(aluControl), 32'h0);
    checkOutput("lw.r1",     r1,              32'h1000);
    checkOutput("lw.r2",     r2,              32'd8);
    checkOutput("lw.funct3", 32'(funct3),     32'h2);
    checkOutput("lw.rdWe",   32'(rdWe),       32'h1);

    // ADDI x0, x0, 1: writeback to x0 suppressed
    applyStimulus(1'b1, 32'h00100013, 32'h210, 32'h0, 32'h0);
    tick();
    checkOutput("x0.rdWe", 32'(rdWe), 32'h0);
    checkOutput("x0.r2",   r2,        32'd1);

    // Illegal encoding still travels as a valid slot
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h214, 32'h55, 32'h66);
    tick();
    checkOutput("ill.valid",   32'(outValid),   32'h1);
    checkOutput("ill.illegal", 32'(illegal),    32'h1);
    checkOutput("ill.rdWe",    32'(rdWe),       32'h0);
    checkOutput("ill.memRe",   32'(memRe),      32'h0);
    checkOutput("ill.memWe",   32'(memWe),      32'h0);
    checkOutput("ill.branch",  32'(branch),     32'h0);
    checkOutput("ill.alu",     32'(aluControl), 32'h0);
    checkOutput("ill.r1",      r1,              32'h0);
    checkOutput("ill.r2",      r2,              32'h0);

    // Asynchronous reset while a slot is stalled
    applyStimulus(1'b1, 32'hFFD08293, 32'h300, 32'd10, 32'h0);
    tick();
    outReady = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("stall2.valid", 32'(outValid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncReset");
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("postReset.inReady", 32'(inReady), 32'h1);
    tick();
    checkOutput("postReset.valid", 32'(outValid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
